// File: rtl/mmio_gpio_bank.sv
// mmio_gpio_bank: NCH memory-mapped GPIO channels of WIDTH bits (OUT, IN, EDGE, MASK).
// Define GPIO_IRQ_EN to build the sticky rising-edge status, per-bit mask and IRQ.
module mmio_gpio_bank #(
    parameter int          WIDTH = 8,
    parameter int          NCH   = 4,
    parameter logic [31:0] BASE  = 32'h800
) (
    input  logic                 clk,
    input  logic                 resetE,
    input  logic [31:0]          Adr,
    input  logic [31:0]          WriteData,
    input  logic                 MemWrite,
    input  logic                 MemtoReg,
    output logic                 Hit,
    output logic [31:0]          ReadData,
    input  logic [NCH*WIDTH-1:0] INport,
    output logic [NCH*WIDTH-1:0] OUTport,
    output logic                 IRQ
);
    localparam int          NBITS = NCH * WIDTH;
    localparam logic [32:0] LIMIT = {1'b0, BASE} + 33'(NCH * 16);

    logic [3:0]       ch;
    logic [1:0]       rsel;
    logic             wr;
    logic [NBITS-1:0] out_q;
    logic [NBITS-1:0] s1_q;
    logic [NBITS-1:0] s2_q;
    logic [WIDTH-1:0] rd;

    // Window compare is done 33 bits wide so a bank ending at 4 GiB cannot wrap.
    assign Hit  = ({1'b0, Adr} >= {1'b0, BASE}) && ({1'b0, Adr} < LIMIT);
    assign ch   = Adr[7:4] - BASE[7:4];
    assign rsel = Adr[3:2];
    assign wr   = Hit & MemWrite;

    always_ff @(posedge clk or negedge resetE) begin
        if (!resetE) begin
            out_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
        end else begin
            s1_q <= INport;
            s2_q <= s1_q;
            for (int c = 0; c < NCH; c++) begin
                if (wr && rsel == 2'd0 && ch == 4'(c))
                    out_q[c*WIDTH +: WIDTH] <= WriteData[WIDTH-1:0];
            end
        end
    end

    assign OUTport = out_q;

`ifdef GPIO_IRQ_EN
    logic [NBITS-1:0] prev_q;
    logic [NBITS-1:0] edge_q;
    logic [NBITS-1:0] mask_q;
    logic [NBITS-1:0] clr;
    logic [NBITS-1:0] rise;

    assign rise = s2_q & ~prev_q;

    always_comb begin
        clr = '0;
        for (int c = 0; c < NCH; c++) begin
            if (wr && rsel == 2'd2 && ch == 4'(c))
                clr[c*WIDTH +: WIDTH] = WriteData[WIDTH-1:0];
        end
    end

    // A rise detected in the same cycle as a write-1-to-clear keeps the bit set.
    always_ff @(posedge clk or negedge resetE) begin
        if (!resetE) begin
            prev_q <= '0;
            edge_q <= '0;
            mask_q <= '0;
        end else begin
            prev_q <= s2_q;
            edge_q <= (edge_q & ~clr) | rise;
            for (int c = 0; c < NCH; c++) begin
                if (wr && rsel == 2'd3 && ch == 4'(c))
                    mask_q[c*WIDTH +: WIDTH] <= WriteData[WIDTH-1:0];
            end
        end
    end

    assign IRQ = |(edge_q & mask_q);
`else
    assign IRQ = 1'b0;
`endif

    always_comb begin
        rd = '0;
        for (int c = 0; c < NCH; c++) begin
            if (ch == 4'(c)) begin
                case (rsel)
                    2'd0:    rd = out_q[c*WIDTH +: WIDTH];
                    2'd1:    rd = s2_q[c*WIDTH +: WIDTH];
`ifdef GPIO_IRQ_EN
                    2'd2:    rd = edge_q[c*WIDTH +: WIDTH];
                    2'd3:    rd = mask_q[c*WIDTH +: WIDTH];
`endif
                    default: rd = '0;
                endcase
            end
        end
        ReadData = '0;
        if (Hit)
            ReadData[WIDTH-1:0] = rd;
    end

    // MemtoReg exists only for bus symmetry; byte offset and upper store bits are don't-care.
    logic unused_ok;
    assign unused_ok = ^{MemtoReg, WriteData, Adr[1:0]};

endmodule

// File: tb/tb_mmio_gpio_bank.sv
// tb_mmio_gpio_bank: randomized and directed checks of mmio_gpio_bank against a
// cycle-level register/sample-history model; builds with or without GPIO_IRQ_EN.
module tb_mmio_gpio_bank;
    localparam int          WIDTH = 8;
    localparam int          NCH   = 4;
    localparam int unsigned BASE  = 32'h800;
    localparam int          NB    = NCH * WIDTH;
`ifdef GPIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk;
    logic          resetE;
    logic [31:0]   Adr;
    logic [31:0]   WriteData;
    logic          MemWrite;
    logic          MemtoReg;
    logic          Hit;
    logic [31:0]   ReadData;
    logic [NB-1:0] INport;
    logic [NB-1:0] OUTport;
    logic          IRQ;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    mmio_gpio_bank #(.WIDTH(WIDTH), .NCH(NCH), .BASE(32'(BASE))) dut (
        .clk(clk), .resetE(resetE), .Adr(Adr), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .Hit(Hit), .ReadData(ReadData),
        .INport(INport), .OUTport(OUTport), .IRQ(IRQ)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Registers per channel plus the last three INport values seen at clock edges:
    // IN shows the value sampled one edge ago, a rise is a 0->1 between the
    // samples taken two and three edges ago.
    logic [WIDTH-1:0] m_out [NCH];
    logic [WIDTH-1:0] m_edge[NCH];
    logic [WIDTH-1:0] m_mask[NCH];
    logic [NB-1:0]    hist  [3];

    function automatic bit in_win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + NCH * 16);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_out[k] = '0; m_edge[k] = '0; m_mask[k] = '0;
        end
        for (int k = 0; k < 3; k++) hist[k] = '0;
    endtask

    task automatic model_edge();
        logic [NB-1:0]    rise;
        logic [WIDTH-1:0] clr;
        bit               w;
        int               c;
        logic [1:0]       r;
        rise = hist[1] & ~hist[2];
        w    = MemWrite && in_win(Adr);
        c    = int'((Adr - BASE) >> 4);
        r    = Adr[3:2];
        for (int k = 0; k < NCH; k++) begin
            clr = (w && k == c && r == 2'd2) ? WriteData[WIDTH-1:0] : '0;
            if (IRQ_EN) m_edge[k] = (m_edge[k] & ~clr) | rise[k*WIDTH +: WIDTH];
            if (w && k == c && r == 2'd0) m_out[k] = WriteData[WIDTH-1:0];
            if (IRQ_EN && w && k == c && r == 2'd3) m_mask[k] = WriteData[WIDTH-1:0];
        end
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = INport;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int c;
        if (!in_win(a)) return 32'h0;
        c = int'((a - BASE) >> 4);
        case (a[3:2])
            2'd0:    return 32'(m_out[c]);
            2'd1:    return 32'(hist[1][c*WIDTH +: WIDTH]);
            2'd2:    return IRQ_EN ? 32'(m_edge[c]) : 32'h0;
            default: return IRQ_EN ? 32'(m_mask[c]) : 32'h0;
        endcase
    endfunction

    function automatic logic exp_irq();
        logic v = 1'b0;
        for (int k = 0; k < NCH; k++) v |= |(m_edge[k] & m_mask[k]);
        return IRQ_EN ? v : 1'b0;
    endfunction

    function automatic logic [NB-1:0] exp_out();
        logic [NB-1:0] v;
        for (int k = 0; k < NCH; k++) v[k*WIDTH +: WIDTH] = m_out[k];
        return v;
    endfunction

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic check_pins(input string tag);
        check({tag, "_out"}, 64'(OUTport), 64'(exp_out()));
        check({tag, "_irq"}, 64'(IRQ), 64'(exp_irq()));
    endtask

    task automatic bus_write(input string tag, input logic [31:0] a, input logic [31:0] d);
        Adr = a; WriteData = d; MemWrite = 1'b1; MemtoReg = 1'b0;
        #1;
        check({tag, "_hit"}, 64'(Hit), 64'(in_win(a)));
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a);
        Adr = a; MemWrite = 1'b0; MemtoReg = 1'b1;
        #1;
        exp_q.push_back(model_read(a));
        check(tag, 64'(ReadData), 64'(exp_q.pop_front()));
        MemtoReg = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        resetE = 1'b0; Adr = '0; WriteData = '0; MemWrite = 1'b0; MemtoReg = 1'b0;
        INport = '1;
        model_reset();

        // Reset held with all inputs high, then released.
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_hold_out", 64'(OUTport), 64'h0);
        check("rst_hold_irq", 64'(IRQ), 64'h0);
        resetE = 1'b1;
        tick(); check_pins("rst_e1");
        check("rst_e1_out0", 64'(OUTport), 64'h0);
        tick(); check_pins("rst_e2");
        tick(); check_pins("rst_e3");
        for (int k = 0; k < NCH; k++) begin
            read_check("rst_edge", 32'(BASE + k * 16 + 8));
            read_check("rst_in", 32'(BASE + k * 16 + 4));
        end
        for (int k = 0; k < NCH; k++) bus_write("rst_clr", 32'(BASE + k * 16 + 8), 32'hFFFF_FFFF);
        INport = '0;
        repeat (3) tick();

        // Output write / readback and an out-of-window store.
        bus_write("w800", 32'(BASE), 32'hFFFF_FFA5);
        check("out_ch0", 64'(OUTport[7:0]), 64'hA5);
        bus_write("w830", 32'(BASE + 32'h30), 32'h0000_003C);
        check("out_ch3", 64'(OUTport[31:24]), 64'h3C);
        check_pins("w830");
        read_check("r830", 32'(BASE + 32'h30));
        bus_write("w840", 32'(BASE + 32'h40), 32'h0000_00FF);
        check_pins("w840");

        // Input synchroniser and edge capture on channel 1.
        INport[15:8] = 8'h81;
        bus_write("mask1", 32'(BASE + 32'h1C), 32'h01);
        tick();
        read_check("in814", 32'(BASE + 32'h14));
        check("in814_val", 64'(ReadData), 64'h81);
        tick();
        read_check("edge818", 32'(BASE + 32'h18));
        check_pins("edge818");

        // Clear-versus-set race on bit 0 of channel 1.
        bus_write("clr_b7", 32'(BASE + 32'h18), 32'h80);
        INport[8] = 1'b0;
        repeat (3) tick();
        INport[8] = 1'b1;
        tick(); tick();
        bus_write("race_clr", 32'(BASE + 32'h18), 32'h01);
        read_check("race_rd", 32'(BASE + 32'h18));
        check_pins("race");
        bus_write("plain_clr", 32'(BASE + 32'h18), 32'h01);
        read_check("plain_rd", 32'(BASE + 32'h18));
        check_pins("plain");

        // Offsets 0x8/0xC on channel 0.
        bus_write("w80c", 32'(BASE + 32'hC), 32'hFF);
        read_check("r80c", 32'(BASE + 32'hC));
        read_check("r808", 32'(BASE + 32'h8));

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) INport = NB'($urandom);
            if ($urandom_range(0, 15) == 0) a = $urandom;
            else a = $urandom_range(BASE + NCH * 16 + 31, BASE - 32);
            Adr = a; WriteData = $urandom;
            MemWrite = 1'($urandom_range(0, 1)); MemtoReg = ~MemWrite;
            #1;
            exp_q.push_back(model_read(a));
            check("rnd_rd", 64'(ReadData), 64'(exp_q.pop_front()));
            check("rnd_hit", 64'(Hit), 64'(in_win(a)));
            tick();
            check_pins("rnd");
        end
        MemWrite = 1'b0;

        // Mid-operation asynchronous reset between edges.
        bus_write("pre_out", 32'(BASE), 32'hFF);
        for (int k = 0; k < NCH; k++) bus_write("pre_mask", 32'(BASE + k * 16 + 12), 32'hFF);
        INport = '0; repeat (3) tick();
        INport = '1; repeat (3) tick();
        check_pins("pre_rst");
        Adr = 32'(BASE);
        #2 resetE = 1'b0;
        #1;
        check("mid_out", 64'(OUTport), 64'h0);
        check("mid_irq", 64'(IRQ), 64'h0);
        check("mid_rd", 64'(ReadData), 64'h0);
        resetE = 1'b1;
        model_reset();
        tick(); check_pins("post_e1");
        read_check("post_edge", 32'(BASE + 8));
        tick(); tick(); check_pins("post_e3");
        read_check("post_edge3", 32'(BASE + 8));
        read_check("post_in", 32'(BASE + 4));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
